// File: rtl/reg_file.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous write port.
// Register 0 is hard-wired to zero; reset clears the whole array.
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        wen,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_addr_0,
  input  logic [4:0]  read_addr_1,
  output logic [31:0] read_data_0,
  output logic [31:0] read_data_1
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (wen && (write_addr != 5'd0)) begin
      regs[write_addr] <= write_data;
    end
  end

  // Index 0 is forced to zero in the mux so it reads 0 even before the first reset.
  always_comb begin
    read_data_0 = (read_addr_0 == 5'd0) ? 32'h0 : regs[read_addr_0];
    read_data_1 = (read_addr_1 == 5'd0) ? 32'h0 : regs[read_addr_1];
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected read values into a queue,
// a monitor pops and compares each one when the stimulus flags the outputs as settled.
`timescale 1ns/1ps
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        wen;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr_0;
  logic [4:0]  read_addr_1;
  logic [31:0] read_data_0;
  logic [31:0] read_data_1;

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  event chk;
  int   checks = 0;
  int   fails  = 0;

  reg_file dut (
    .clk         (clk),
    .reset       (reset),
    .wen         (wen),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr_0 (read_addr_0),
    .read_addr_1 (read_addr_1),
    .read_data_0 (read_data_0),
    .read_data_1 (read_data_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one pop-and-compare per presented output sample.
  initial begin
    exp_t        it;
    logic [31:0] act;
    forever begin
      @(chk);
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL monitor: output presented with empty scoreboard, actual %0d required >0 entries", q.size());
      end else begin
        it  = q.pop_front();
        act = (it.port == 1) ? read_data_1 : read_data_0;
        checks++;
        if (act !== it.exp) begin
          fails++;
          $display("FAIL %s: read_data_%0d actual %h required %h", it.name, it.port, act, it.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_rd(input int port, input logic [31:0] exp, input string name);
    exp_t it;
    #1;
    it.port = port;
    it.exp  = exp;
    it.name = name;
    q.push_back(it);
    ->chk;
    #1;
  endtask

  task automatic expect_all_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      read_addr_0 = a[4:0];
      read_addr_1 = 5'(31 - a);
      expect_rd(0, 32'h0, name);
      expect_rd(1, 32'h0, name);
    end
  endtask

  initial begin
    reset = 1'b0; wen = 1'b0; write_addr = '0; write_data = '0;
    read_addr_0 = '0; read_addr_1 = '0;
    @(negedge clk);
    expect_rd(0, 32'h0, "pre_reset_r0");

    // Reset, then basic write
    reset = 1'b1; tick(); reset = 1'b0;
    expect_all_zero("after_reset");

    wen = 1'b1; write_addr = 5'd3; write_data = 32'd123; read_addr_0 = 5'd3;
    tick(); wen = 1'b0;
    expect_rd(0, 32'd123, "basic_write_r3");

    read_addr_1 = 5'd3;
    expect_rd(1, 32'd123, "port1_read_r3");

    // Write to register 0
    wen = 1'b1; write_addr = 5'd0; write_data = 32'd111; read_addr_0 = 5'd0;
    tick(); wen = 1'b0;
    expect_rd(0, 32'h0, "write_zero_reg");

    // Dual read and no bypass
    wen = 1'b1; write_addr = 5'd5;  write_data = 32'hDEADBEEF; tick();
    write_addr = 5'd31; write_data = 32'h12345678; tick();
    wen = 1'b0;
    read_addr_0 = 5'd5; read_addr_1 = 5'd31;
    expect_rd(0, 32'hDEADBEEF, "dual_read_r5");
    expect_rd(1, 32'h12345678, "dual_read_r31");

    wen = 1'b1; write_addr = 5'd5; write_data = 32'd7;
    expect_rd(0, 32'hDEADBEEF, "no_bypass_before_edge");
    tick(); wen = 1'b0;
    expect_rd(0, 32'd7, "no_bypass_after_edge");
    expect_rd(1, 32'h12345678, "r31_untouched");

    // wen low
    wen = 1'b0; write_addr = 5'd5; write_data = 32'd99;
    tick();
    expect_rd(0, 32'd7, "wen_low_r5");

    // Reset priority over a simultaneous write
    read_addr_0 = 5'd3; read_addr_1 = 5'd5;
    reset = 1'b1; wen = 1'b1; write_addr = 5'd3; write_data = 32'd55;
    expect_rd(0, 32'd123, "reset_no_async_effect");
    tick(); reset = 1'b0; wen = 1'b0;
    expect_rd(0, 32'h0, "reset_priority_r3");
    expect_rd(1, 32'h0, "reset_clears_r5");
    expect_all_zero("after_reset_priority");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && q.size() != 0; i++) #1;
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: pending entries actual %0d required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
